cop0_write_sequencer: RTL and testbench

Owns the single write port of the CP0 register file and shares it between the pipeline's `mtc0` path, the exception and `eret` logic, the LL unit and the hardware-interrupt lines. An exception needs several CP0 fields updated: BadVAddr, EPC, Cause and Status.EXL. The block expands each exception into an atomic, back-to-back sequence of masked writes. Every write leaves through one registered port. Any `mtc0` data reaching this block has already been masked by the CP0 write filter.

---
 rtl/cop0_write_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_cop0_write_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_write_sequencer.sv
// cop0_write_sequencer: sole owner of the CP0 register-file write port.
// Arbitrates exception entry, eret, mtc0, LL and hardware-interrupt updates.
// Each exception expands into an atomic, back-to-back burst of masked writes.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mtc0_valid/ready/rd/sel/data/wmask   filtered mtc0 write request
//   exc_valid/ready/epc/code/bd/bv_valid/badvaddr   exception entry
//   eret_valid/ready                eret request (clears Status.EXL)
//   ll_valid/ready/addr             LLAddr update request
//   hw_int                          level interrupt lines -> Cause.IP7..IP2
//   cop0_we/rd/sel/wdata/wmask      registered masked write port
//   exc_done                        pulse with the exception's Status write
//   busy                            exception sequence in progress
module cop0_write_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mtc0_valid,
  output logic        mtc0_ready,
  input  logic [4:0]  mtc0_rd,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  input  logic [31:0] mtc0_wmask,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [31:0] exc_epc,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic        exc_bv_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  output logic        eret_ready,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [31:0] ll_addr,
  input  logic [5:0]  hw_int,
  output logic        cop0_we,
  output logic [4:0]  cop0_rd,
  output logic [2:0]  cop0_sel,
  output logic [31:0] cop0_wdata,
  output logic [31:0] cop0_wmask,
  output logic        exc_done,
  output logic        busy
);

  localparam logic [4:0]  RD_BADVADDR = 5'd8;
  localparam logic [4:0]  RD_STATUS   = 5'd12;
  localparam logic [4:0]  RD_CAUSE    = 5'd13;
  localparam logic [4:0]  RD_EPC      = 5'd14;
  localparam logic [4:0]  RD_LLADDR   = 5'd17;
  localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_EXC    = 32'h8000_007C;
  localparam logic [31:0] MASK_EXL    = 32'h0000_0002;
  localparam logic [31:0] MASK_IP     = 32'h0000_FC00;

  // Each non-IDLE state names the next exception write to be loaded.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    S_EPC    = 2'd1,
    S_CAUSE  = 2'd2,
    S_STATUS = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [5:0]  hw_int_q, hw_int_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wmask_q, wmask_d;
  logic        exc_done_q, exc_done_d;
  logic        busy_q, busy_d;
  logic        idle;

  assign idle       = (state_q == IDLE);
  assign exc_ready  = idle;
  assign eret_ready = idle & ~exc_valid;
  assign mtc0_ready = idle & ~exc_valid & ~eret_valid;
  assign ll_ready   = idle & ~exc_valid & ~eret_valid & ~mtc0_valid;

  // Arbitration, exception sequencing and next write-port contents.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    code_d     = code_q;
    bd_d       = bd_q;
    hw_int_d   = hw_int_q;
    we_d       = 1'b0;
    rd_d       = rd_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    exc_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exc_valid) begin
          epc_d  = exc_epc;
          code_d = exc_code;
          bd_d   = exc_bd;
          we_d   = 1'b1;
          sel_d  = 3'd0;
          wmask_d = MASK_ALL;
          if (exc_bv_valid) begin
            rd_d    = RD_BADVADDR;
            wdata_d = exc_badvaddr;
            state_d = S_EPC;
          end else begin
            // No BadVAddr: EPC goes out first, straight from the request.
            rd_d    = RD_EPC;
            wdata_d = exc_epc;
            state_d = S_CAUSE;
          end
        end else if (eret_valid) begin
          we_d    = 1'b1;
          rd_d    = RD_STATUS;
          sel_d   = 3'd0;
          wdata_d = 32'h0;
          wmask_d = MASK_EXL;
        end else if (mtc0_valid) begin
          we_d    = 1'b1;
          rd_d    = mtc0_rd;
          sel_d   = mtc0_sel;
          wdata_d = mtc0_data;
          wmask_d = mtc0_wmask;
        end else if (ll_valid) begin
          we_d    = 1'b1;
          rd_d    = RD_LLADDR;
          sel_d   = 3'd0;
          wdata_d = ll_addr;
          wmask_d = MASK_ALL;
        end else if (hw_int != hw_int_q) begin
          // Lowest priority: only the current level is written, so glitches
          // that settle back while busy never reach Cause.
          we_d     = 1'b1;
          rd_d     = RD_CAUSE;
          sel_d    = 3'd0;
          wdata_d  = {16'h0, hw_int, 10'h0};
          wmask_d  = MASK_IP;
          hw_int_d = hw_int;
        end
      end
      S_EPC: begin
        we_d    = 1'b1;
        rd_d    = RD_EPC;
        sel_d   = 3'd0;
        wdata_d = epc_q;
        wmask_d = MASK_ALL;
        state_d = S_CAUSE;
      end
      S_CAUSE: begin
        we_d    = 1'b1;
        rd_d    = RD_CAUSE;
        sel_d   = 3'd0;
        wdata_d = {bd_q, 24'h0, code_q, 2'b00};
        wmask_d = MASK_EXC;
        state_d = S_STATUS;
      end
      S_STATUS: begin
        we_d       = 1'b1;
        rd_d       = RD_STATUS;
        sel_d      = 3'd0;
        wdata_d    = MASK_EXL;
        wmask_d    = MASK_EXL;
        exc_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any partial sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      epc_q      <= 32'h0;
      code_q     <= 5'h0;
      bd_q       <= 1'b0;
      hw_int_q   <= 6'h0;
      we_q       <= 1'b0;
      rd_q       <= 5'h0;
      sel_q      <= 3'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 32'h0;
      exc_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      hw_int_q   <= hw_int_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      exc_done_q <= exc_done_d;
      busy_q     <= busy_d;
    end
  end

  assign cop0_we    = we_q;
  assign cop0_rd    = rd_q;
  assign cop0_sel   = sel_q;
  assign cop0_wdata = wdata_q;
  assign cop0_wmask = wmask_q;
  assign exc_done   = exc_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cop0_write_sequencer.sv
// Self-checking bench for cop0_write_sequencer: directed scenarios plus a
// randomized run against a transaction-level model (queue of pending writes).
module tb_cop0_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mtc0_valid, mtc0_ready;
  logic [4:0]  mtc0_rd;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_data, mtc0_wmask;
  logic        exc_valid, exc_ready;
  logic [31:0] exc_epc;
  logic [4:0]  exc_code;
  logic        exc_bd, exc_bv_valid;
  logic [31:0] exc_badvaddr;
  logic        eret_valid, eret_ready;
  logic        ll_valid, ll_ready;
  logic [31:0] ll_addr;
  logic [5:0]  hw_int;
  logic        cop0_we;
  logic [4:0]  cop0_rd;
  logic [2:0]  cop0_sel;
  logic [31:0] cop0_wdata, cop0_wmask;
  logic        exc_done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [31:0] mask;
    logic        done;
  } wr_t;

  cop0_write_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .mtc0_valid(mtc0_valid), .mtc0_ready(mtc0_ready), .mtc0_rd(mtc0_rd),
    .mtc0_sel(mtc0_sel), .mtc0_data(mtc0_data), .mtc0_wmask(mtc0_wmask),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_epc(exc_epc),
    .exc_code(exc_code), .exc_bd(exc_bd), .exc_bv_valid(exc_bv_valid),
    .exc_badvaddr(exc_badvaddr),
    .eret_valid(eret_valid), .eret_ready(eret_ready),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr),
    .hw_int(hw_int),
    .cop0_we(cop0_we), .cop0_rd(cop0_rd), .cop0_sel(cop0_sel),
    .cop0_wdata(cop0_wdata), .cop0_wmask(cop0_wmask),
    .exc_done(exc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mtc0_valid = 0; mtc0_rd = 0; mtc0_sel = 0; mtc0_data = 0; mtc0_wmask = 0;
    exc_valid = 0; exc_epc = 0; exc_code = 0; exc_bd = 0; exc_bv_valid = 0;
    exc_badvaddr = 0; eret_valid = 0; ll_valid = 0; ll_addr = 0; hw_int = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    n_tests++; if (cop0_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", cop0_we); end
    n_tests++; if (cop0_rd !== 5'd0 || cop0_sel !== 3'd0) begin n_fail++; $display("FAIL reset_target got %h/%h exp 0/0", cop0_rd, cop0_sel); end
    n_tests++; if (cop0_wdata !== 32'h0 || cop0_wmask !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", cop0_wdata, cop0_wmask); end
    n_tests++; if (exc_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%b busy=%b exp 0/0", exc_done, busy); end
    rst_n = 1;
    #1;
    n_tests++; if ({exc_ready, eret_ready, mtc0_ready, ll_ready} !== 4'b1111) begin n_fail++; $display("FAIL reset_readies got %b exp 1111", {exc_ready, eret_ready, mtc0_ready, ll_ready}); end
    tick();
  endtask

  task automatic test_mtc0();
    mtc0_valid = 1; mtc0_rd = 5'd12; mtc0_sel = 3'd0;
    mtc0_data = 32'h0000_0401; mtc0_wmask = 32'h1040_FF17;
    #1;
    n_tests++; if (mtc0_ready !== 1'b1) begin n_fail++; $display("FAIL mtc0_ready got %b exp 1", mtc0_ready); end
    tick();
    mtc0_valid = 0;
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd12 || cop0_sel !== 3'd0) begin n_fail++; $display("FAIL mtc0_write got we=%b rd=%0d sel=%0d exp 1/12/0", cop0_we, cop0_rd, cop0_sel); end
    n_tests++; if (cop0_wdata !== 32'h0000_0401 || cop0_wmask !== 32'h1040_FF17) begin n_fail++; $display("FAIL mtc0_data got %h/%h exp 00000401/1040ff17", cop0_wdata, cop0_wmask); end
    tick();
    n_tests++; if (cop0_we !== 1'b0 || cop0_rd !== 5'd12) begin n_fail++; $display("FAIL mtc0_hold got we=%b rd=%0d exp 0/12", cop0_we, cop0_rd); end
  endtask

  task automatic test_exc_bv();
    logic [4:0]  e_rd   [4] = '{5'd8, 5'd14, 5'd13, 5'd12};
    logic [31:0] e_data [4] = '{32'h0000_1234, 32'hBFC0_0010, 32'h8000_0010, 32'h2};
    logic [31:0] e_mask [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_007C, 32'h2};
    exc_valid = 1; exc_bv_valid = 1; exc_badvaddr = 32'h0000_1234;
    exc_epc = 32'hBFC0_0010; exc_code = 5'd4; exc_bd = 1;
    #1;
    n_tests++; if (exc_ready !== 1'b1) begin n_fail++; $display("FAIL excbv_ready got %b exp 1", exc_ready); end
    tick();
    exc_valid = 0; exc_bv_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cop0_we !== 1'b1 || cop0_rd !== e_rd[i] || cop0_sel !== 3'd0 || cop0_wdata !== e_data[i] || cop0_wmask !== e_mask[i])
        begin n_fail++; $display("FAIL excbv_write%0d got we=%b rd=%0d data=%h mask=%h exp 1/%0d/%h/%h", i, cop0_we, cop0_rd, cop0_wdata, cop0_wmask, e_rd[i], e_data[i], e_mask[i]); end
      n_tests++;
      if (exc_done !== (i == 3) || busy !== (i != 3))
        begin n_fail++; $display("FAIL excbv_flags%0d got done=%b busy=%b exp %b/%b", i, exc_done, busy, i == 3, i != 3); end
      n_tests++;
      if (exc_ready !== (i == 3)) begin n_fail++; $display("FAIL excbv_ready%0d got %b exp %b", i, exc_ready, i == 3); end
      tick();
    end
    n_tests++; if (cop0_we !== 1'b0 || exc_done !== 1'b0) begin n_fail++; $display("FAIL excbv_end got we=%b done=%b exp 0/0", cop0_we, exc_done); end
  endtask

  task automatic test_exc_race();
    exc_valid = 1; exc_bv_valid = 0; exc_epc = 32'h8000_0180; exc_code = 5'd10; exc_bd = 0;
    mtc0_valid = 1; mtc0_rd = 5'd9; mtc0_sel = 3'd0; mtc0_data = 32'h0000_A5A5; mtc0_wmask = 32'h0000_FFFF;
    ll_valid = 1; ll_addr = 32'h1000_0040;
    #1;
    n_tests++; if ({exc_ready, eret_ready, mtc0_ready, ll_ready} !== 4'b1000) begin n_fail++; $display("FAIL race_readies got %b exp 1000", {exc_ready, eret_ready, mtc0_ready, ll_ready}); end
    tick();
    exc_valid = 0;
    #1;
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd14 || cop0_wdata !== 32'h8000_0180) begin n_fail++; $display("FAIL race_epc got we=%b rd=%0d data=%h exp 1/14/80000180", cop0_we, cop0_rd, cop0_wdata); end
    n_tests++; if (mtc0_ready !== 1'b0 || ll_ready !== 1'b0) begin n_fail++; $display("FAIL race_wait1 got %b%b exp 00", mtc0_ready, ll_ready); end
    tick();
    n_tests++; if (cop0_rd !== 5'd13 || cop0_wdata !== 32'h0000_0028 || cop0_wmask !== 32'h8000_007C) begin n_fail++; $display("FAIL race_cause got rd=%0d data=%h mask=%h exp 13/00000028/8000007c", cop0_rd, cop0_wdata, cop0_wmask); end
    n_tests++; if (mtc0_ready !== 1'b0 || ll_ready !== 1'b0) begin n_fail++; $display("FAIL race_wait2 got %b%b exp 00", mtc0_ready, ll_ready); end
    tick();
    n_tests++; if (cop0_rd !== 5'd12 || exc_done !== 1'b1) begin n_fail++; $display("FAIL race_status got rd=%0d done=%b exp 12/1", cop0_rd, exc_done); end
    n_tests++; if (mtc0_ready !== 1'b1 || ll_ready !== 1'b0) begin n_fail++; $display("FAIL race_mtc0_ready got %b%b exp 10", mtc0_ready, ll_ready); end
    tick();
    mtc0_valid = 0;
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd9 || cop0_wdata !== 32'h0000_A5A5 || cop0_wmask !== 32'h0000_FFFF) begin n_fail++; $display("FAIL race_mtc0 got rd=%0d data=%h mask=%h exp 9/0000a5a5/0000ffff", cop0_rd, cop0_wdata, cop0_wmask); end
    #1;
    n_tests++; if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL race_ll_ready got %b exp 1", ll_ready); end
    tick();
    ll_valid = 0;
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd17 || cop0_wdata !== 32'h1000_0040 || cop0_wmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL race_ll got rd=%0d data=%h mask=%h exp 17/10000040/ffffffff", cop0_rd, cop0_wdata, cop0_wmask); end
    tick();
    n_tests++; if (cop0_we !== 1'b0) begin n_fail++; $display("FAIL race_end got we=%b exp 0", cop0_we); end
  endtask

  task automatic test_irq_eret();
    int writes;
    hw_int = 6'b100001;
    tick();
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd13 || cop0_wdata !== 32'h0000_8400 || cop0_wmask !== 32'h0000_FC00) begin n_fail++; $display("FAIL irq_cause got we=%b rd=%0d data=%h mask=%h exp 1/13/00008400/0000fc00", cop0_we, cop0_rd, cop0_wdata, cop0_wmask); end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cop0_we === 1'b1) writes++;
    end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL irq_norepeat got %0d writes exp 0", writes); end
    eret_valid = 1;
    #1;
    n_tests++; if (eret_ready !== 1'b1) begin n_fail++; $display("FAIL eret_ready got %b exp 1", eret_ready); end
    tick();
    eret_valid = 0;
    n_tests++; if (cop0_we !== 1'b1 || cop0_rd !== 5'd12 || cop0_wdata !== 32'h0 || cop0_wmask !== 32'h2) begin n_fail++; $display("FAIL eret_write got we=%b rd=%0d data=%h mask=%h exp 1/12/00000000/00000002", cop0_we, cop0_rd, cop0_wdata, cop0_wmask); end
    tick();
  endtask

  task automatic test_reset_mid();
    int writes;
    rst_n = 0; clear_inputs();
    tick();
    rst_n = 1;
    exc_valid = 1; exc_bv_valid = 1; exc_badvaddr = 32'hDEAD_0000;
    exc_epc = 32'h0040_0100; exc_code = 5'd5; exc_bd = 0;
    tick();
    clear_inputs();
    tick();
    // Now in the cycle that holds S_CAUSE.
    rst_n = 0;
    tick();
    n_tests++; if (cop0_we !== 1'b0 || cop0_rd !== 5'd0 || cop0_sel !== 3'd0 || cop0_wdata !== 32'h0 || cop0_wmask !== 32'h0 || exc_done !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL midrst_outputs got we=%b rd=%0d data=%h mask=%h done=%b busy=%b exp all 0", cop0_we, cop0_rd, cop0_wdata, cop0_wmask, exc_done, busy); end
    rst_n = 1;
    #1;
    n_tests++; if (exc_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", exc_ready); end
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cop0_we === 1'b1) writes++;
    end
    n_tests++; if (writes != 0) begin n_fail++; $display("FAIL midrst_stale got %0d writes exp 0", writes); end
  endtask

  // Randomized traffic against a model: an accepted request becomes a list of
  // writes appended to a queue; one write leaves per cycle; idle == queue empty.
  task automatic test_random();
    wr_t        q[$];
    wr_t        cur;
    wr_t        w;
    logic       cur_we;
    logic [5:0] last_ip;
    logic       idle;
    bit         p_exc, p_eret, p_mtc0, p_ll;
    rst_n = 0; clear_inputs();
    tick();
    rst_n = 1;
    cur = '{rd: 5'd0, sel: 3'd0, data: 32'h0, mask: 32'h0, done: 1'b0};
    cur_we = 0; last_ip = 6'd0; q.delete();
    p_exc = 0; p_eret = 0; p_mtc0 = 0; p_ll = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_tests++;
      if (cop0_we !== cur_we || cop0_rd !== cur.rd || cop0_sel !== cur.sel || cop0_wdata !== cur.data || cop0_wmask !== cur.mask)
        begin n_fail++; $display("FAIL rand_port cyc=%0d got we=%b rd=%0d sel=%0d data=%h mask=%h exp we=%b rd=%0d sel=%0d data=%h mask=%h", cyc, cop0_we, cop0_rd, cop0_sel, cop0_wdata, cop0_wmask, cur_we, cur.rd, cur.sel, cur.data, cur.mask); end
      n_tests++;
      if (exc_done !== (cur_we & cur.done) || busy !== (q.size() != 0))
        begin n_fail++; $display("FAIL rand_flags cyc=%0d got done=%b busy=%b exp %b/%b", cyc, exc_done, busy, cur_we & cur.done, q.size() != 0); end

      if (!p_exc && $urandom_range(0, 9) == 0) begin
        p_exc = 1; exc_epc = $urandom; exc_code = 5'($urandom); exc_bd = 1'($urandom);
        exc_bv_valid = 1'($urandom); exc_badvaddr = $urandom;
      end
      if (!p_eret && $urandom_range(0, 5) == 0) p_eret = 1;
      if (!p_mtc0 && $urandom_range(0, 2) == 0) begin
        p_mtc0 = 1; mtc0_rd = 5'($urandom); mtc0_sel = 3'($urandom);
        mtc0_data = $urandom; mtc0_wmask = $urandom;
      end
      if (!p_ll && $urandom_range(0, 3) == 0) begin p_ll = 1; ll_addr = $urandom; end
      exc_valid = p_exc; eret_valid = p_eret; mtc0_valid = p_mtc0; ll_valid = p_ll;
      if ($urandom_range(0, 4) == 0) hw_int = 6'($urandom);
      #1;
      idle = (q.size() == 0);
      n_tests++;
      if (exc_ready !== idle || eret_ready !== (idle & !p_exc) || mtc0_ready !== (idle & !p_exc & !p_eret) || ll_ready !== (idle & !p_exc & !p_eret & !p_mtc0))
        begin n_fail++; $display("FAIL rand_ready cyc=%0d got %b%b%b%b exp %b%b%b%b", cyc, exc_ready, eret_ready, mtc0_ready, ll_ready, idle, idle & !p_exc, idle & !p_exc & !p_eret, idle & !p_exc & !p_eret & !p_mtc0); end

      if (idle) begin
        if (p_exc) begin
          if (exc_bv_valid) q.push_back('{rd: 5'd8, sel: 3'd0, data: exc_badvaddr, mask: 32'hFFFF_FFFF, done: 1'b0});
          q.push_back('{rd: 5'd14, sel: 3'd0, data: exc_epc, mask: 32'hFFFF_FFFF, done: 1'b0});
          q.push_back('{rd: 5'd13, sel: 3'd0, data: (32'(exc_bd) << 31) | (32'(exc_code) << 2), mask: 32'h8000_007C, done: 1'b0});
          q.push_back('{rd: 5'd12, sel: 3'd0, data: 32'h2, mask: 32'h2, done: 1'b1});
          p_exc = 0;
        end else if (p_eret) begin
          q.push_back('{rd: 5'd12, sel: 3'd0, data: 32'h0, mask: 32'h2, done: 1'b0});
          p_eret = 0;
        end else if (p_mtc0) begin
          q.push_back('{rd: mtc0_rd, sel: mtc0_sel, data: mtc0_data, mask: mtc0_wmask, done: 1'b0});
          p_mtc0 = 0;
        end else if (p_ll) begin
          q.push_back('{rd: 5'd17, sel: 3'd0, data: ll_addr, mask: 32'hFFFF_FFFF, done: 1'b0});
          p_ll = 0;
        end else if (hw_int != last_ip) begin
          q.push_back('{rd: 5'd13, sel: 3'd0, data: 32'(hw_int) * 32'd1024, mask: 32'h0000_FC00, done: 1'b0});
          last_ip = hw_int;
        end
      end
      if (q.size() != 0) begin
        w = q.pop_front();
        cur = w;
        cur_we = 1;
      end else begin
        cur_we = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_exc_bv();
    test_exc_race();
    test_irq_eret();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
